// File: rtl/bsram_arbiter.sv
// bsram_arbiter: round-robin arbiter that shares one single-port, registered-output
// block RAM among N_REQ requesters. Each access takes three cycles (IDLE grant,
// ISSUE, CAPTURE), and the ack lands in the following IDLE cycle.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | sample req, pick winner, load ram_* outputs, pulse gnt next cycle
// S_ISSUE   | ram_ce (and ram_we for writes) high; RAM executes at closing edge
// S_CAPTURE | ram_ce low; registered ram_dout valid; latch rdata, raise ack
module bsram_arbiter #(
    parameter int A_SIZE = 10,
    parameter int W_SIZE = 16,
    parameter int N_REQ  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           we,
    input  logic [N_REQ*A_SIZE-1:0]    addr,
    input  logic [N_REQ*W_SIZE-1:0]    wdata,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           ack,
    output logic [W_SIZE-1:0]          rdata,
    output logic                       busy,
    output logic                       ram_ce,
    output logic                       ram_we,
    output logic [A_SIZE-1:0]          ram_addr,
    output logic [W_SIZE-1:0]          ram_din,
    input  logic [W_SIZE-1:0]          ram_dout
);

    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       cur_q, cur_d;
    logic                op_we_q, op_we_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic [W_SIZE-1:0]   rdata_q, rdata_d;
    logic                ram_ce_q, ram_ce_d;
    logic                ram_we_q, ram_we_d;
    logic [A_SIZE-1:0]   ram_addr_q, ram_addr_d;
    logic [W_SIZE-1:0]   ram_din_q, ram_din_d;

    logic                win_found;
    logic [IW-1:0]       win_idx;
    logic [IW-1:0]       cand_idx;

    // Round-robin search: first requester at or above ptr, wrapping at N_REQ-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_idx = IW'((int'(ptr_q) + k) % N_REQ);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Next-state and registered-output computation for the access sequencer.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cur_d      = cur_q;
        op_we_d    = op_we_q;
        gnt_d      = '0;
        ack_d      = '0;
        rdata_d    = rdata_q;
        ram_ce_d   = 1'b0;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    gnt_d[win_idx] = 1'b1;
                    ram_ce_d       = 1'b1;
                    ram_we_d       = we[win_idx];
                    ram_addr_d     = addr[int'(win_idx)*A_SIZE +: A_SIZE];
                    ram_din_d      = wdata[int'(win_idx)*W_SIZE +: W_SIZE];
                    cur_d          = win_idx;
                    op_we_d        = we[win_idx];
                    ptr_d          = (win_idx == IW'(N_REQ-1)) ? '0 : win_idx + IW'(1);
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                ack_d[cur_q] = 1'b1;
                if (!op_we_q) begin
                    rdata_d = ram_dout;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            cur_q      <= '0;
            op_we_q    <= 1'b0;
            gnt_q      <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            ram_ce_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cur_q      <= cur_d;
            op_we_q    <= op_we_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            ram_ce_q   <= ram_ce_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
        end
    end

    assign gnt      = gnt_q;
    assign ack      = ack_q;
    assign rdata    = rdata_q;
    assign busy     = (state_q != S_IDLE);
    assign ram_ce   = ram_ce_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_bsram_arbiter.sv
// Testbench for bsram_arbiter: directed transaction table, multi-cycle corner
// sequences, and randomized traffic against a transaction-level reference model.
module tb_bsram_arbiter;

    localparam int N = 4;
    localparam int A = 10;
    localparam int W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N-1:0]     we = '0;
    logic [N*A-1:0]   addr_bus = '0;
    logic [N*W-1:0]   wdata_bus = '0;
    logic [N-1:0]     gnt, ack;
    logic [W-1:0]     rdata;
    logic             busy, ram_ce, ram_we;
    logic [A-1:0]     ram_addr;
    logic [W-1:0]     ram_din;
    logic [W-1:0]     ram_dout = '0;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    bsram_arbiter #(.A_SIZE(A), .W_SIZE(W), .N_REQ(N)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr_bus),
        .wdata(wdata_bus), .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Registered-output single-port RAM attached to the DUT.
    logic [W-1:0] ram_mem [0:(1<<A)-1];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) ram_mem[ram_addr] <= ram_din;
            else        ram_dout <= ram_mem[ram_addr];
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    logic [W-1:0] ref_mem [0:(1<<A)-1];
    int           m_phase, m_ptr, m_w, m_pick;
    logic         m_op;
    logic [W-1:0] m_rd;
    logic [N-1:0] e_gnt, e_ack;
    logic         e_ce, e_we;
    logic [A-1:0] e_addr;
    logic [W-1:0] e_din, e_rdata;

    always_comb m_pick = pick(req, m_ptr);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0; m_ptr <= 0; m_w <= 0; m_op <= 1'b0; m_rd <= '0;
            e_gnt <= '0; e_ack <= '0; e_ce <= 1'b0; e_we <= 1'b0;
            e_addr <= '0; e_din <= '0; e_rdata <= '0;
        end else begin
            case (m_phase)
                0: begin
                    e_ack <= '0;
                    if (m_pick >= 0) begin
                        e_gnt <= '0;
                        e_gnt[m_pick] <= 1'b1;
                        e_ce <= 1'b1;
                        e_we <= we[m_pick];
                        e_addr <= addr_bus[m_pick*A +: A];
                        e_din <= wdata_bus[m_pick*W +: W];
                        m_w <= m_pick;
                        m_op <= we[m_pick];
                        m_ptr <= (m_pick + 1) % N;
                        m_phase <= 1;
                    end
                end
                1: begin
                    e_gnt <= '0; e_ce <= 1'b0; e_we <= 1'b0;
                    if (m_op) ref_mem[e_addr] <= e_din;
                    else      m_rd <= ref_mem[e_addr];
                    m_phase <= 2;
                end
                default: begin
                    e_ack <= '0;
                    e_ack[m_w] <= 1'b1;
                    if (!m_op) e_rdata <= m_rd;
                    m_phase <= 0;
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("m_gnt", 32'(gnt), 32'(e_gnt));
            cmp("m_ack", 32'(ack), 32'(e_ack));
            cmp("m_busy", 32'(busy), 32'(m_phase != 0));
            cmp("m_ce", 32'(ram_ce), 32'(e_ce));
            cmp("m_we", 32'(ram_we), 32'(e_we));
            cmp("m_addr", 32'(ram_addr), 32'(e_addr));
            cmp("m_din", 32'(ram_din), 32'(e_din));
            cmp("m_rdata", 32'(rdata), 32'(e_rdata));
            cmp("we_without_ce", 32'(ram_we & ~ram_ce), 32'd0);
            cmp("gnt_onehot0", 32'($countones(gnt) <= 1), 32'd1);
            cmp("ack_onehot0", 32'($countones(ack) <= 1), 32'd1);
        end
    end

    // ---------------- directed stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0;
        step(); step();
        reset = 1'b0;
    endtask

    typedef struct {
        int           id;
        bit           wr;
        logic [A-1:0] a;
        logic [W-1:0] d;
        logic [W-1:0] exp_rdata;
    } vec_t;

    vec_t tbl [9];

    initial begin
        for (int i = 0; i < (1<<A); i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        tbl[0] = '{1, 1'b1, 10'h005, 16'hBEEF, 16'h0000};
        tbl[1] = '{1, 1'b0, 10'h005, 16'h0000, 16'hBEEF};
        tbl[2] = '{2, 1'b1, 10'h005, 16'h1234, 16'hBEEF};
        tbl[3] = '{3, 1'b0, 10'h005, 16'h0000, 16'h1234};
        tbl[4] = '{0, 1'b1, 10'h3FF, 16'hA5A5, 16'h1234};
        tbl[5] = '{0, 1'b0, 10'h3FF, 16'h0000, 16'hA5A5};
        tbl[6] = '{2, 1'b0, 10'h007, 16'h0000, 16'h0000};
        tbl[7] = '{3, 1'b1, 10'h007, 16'h0F0F, 16'h0000};
        tbl[8] = '{1, 1'b0, 10'h007, 16'h0000, 16'h0F0F};

        #1 chk_en = 1'b1;
        step();
        cmp("rst_gnt", 32'(gnt), 32'd0);
        cmp("rst_busy", 32'(busy), 32'd0);
        cmp("rst_ce", 32'(ram_ce), 32'd0);
        cmp("rst_rdata", 32'(rdata), 32'd0);
        do_reset();

        // Table: single-requester transactions, issued back to back.
        for (int v = 0; v < 9; v++) begin
            req = '0; req[tbl[v].id] = 1'b1;
            we = '0;  we[tbl[v].id] = tbl[v].wr;
            addr_bus[tbl[v].id*A +: A] = tbl[v].a;
            wdata_bus[tbl[v].id*W +: W] = tbl[v].d;
            step();
            cmp("tbl_gnt", 32'(gnt), 32'(1 << tbl[v].id));
            cmp("tbl_ce", 32'(ram_ce), 32'd1);
            cmp("tbl_we", 32'(ram_we), 32'(tbl[v].wr));
            cmp("tbl_addr", 32'(ram_addr), 32'(tbl[v].a));
            req = '0;
            we = '1;
            addr_bus = '1;
            step();
            cmp("tbl_gnt_off", 32'(gnt), 32'd0);
            cmp("tbl_ce_off", 32'(ram_ce), 32'd0);
            cmp("tbl_addr_hold", 32'(ram_addr), 32'(tbl[v].a));
            step();
            cmp("tbl_ack", 32'(ack), 32'(1 << tbl[v].id));
            cmp("tbl_rdata", 32'(rdata), 32'(tbl[v].exp_rdata));
            cmp("tbl_busy", 32'(busy), 32'd0);
        end

        // All four requesters held with reads: grants 0,1,2,3,0 every 3 cycles.
        do_reset();
        we = '0;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            step();
            cmp("rr_gnt", 32'(gnt), 32'(1 << (g % 4)));
            step();
            cmp("rr_gnt_gap1", 32'(gnt), 32'd0);
            step();
            cmp("rr_gnt_gap2", 32'(gnt), 32'd0);
            cmp("rr_ack", 32'(ack), 32'(1 << (g % 4)));
        end
        req = '0;
        step(); step();

        // Fairness from ptr=2 with req=0011.
        do_reset();
        req = 4'b0010;
        step();
        cmp("fair_setup", 32'(gnt), 32'b0010);
        req = '0;
        step(); step();
        req = 4'b0011;
        step();
        cmp("fair_first", 32'(gnt), 32'b0001);
        req = 4'b0010;
        step(); step(); step();
        cmp("fair_second", 32'(gnt), 32'b0010);
        req = '0;
        step(); step();
        req = 4'b0101;
        step();
        cmp("fair_ptr2", 32'(gnt), 32'b0100);
        req = '0;
        step(); step();

        // req[3] pulsed only during ISSUE must not be served.
        do_reset();
        req = 4'b0001;
        step();
        cmp("pulse_gnt0", 32'(gnt), 32'b0001);
        cmp("pulse_ce_on", 32'(ram_ce), 32'd1);
        req = 4'b1000;
        step();
        cmp("pulse_ce_off", 32'(ram_ce), 32'd0);
        req = '0;
        step();
        cmp("pulse_ack0", 32'(ack), 32'b0001);
        step();
        cmp("pulse_no_gnt3", 32'(gnt), 32'd0);
        cmp("pulse_idle", 32'(busy), 32'd0);

        // Reset during CAPTURE of a read aborts it; ptr returns to 0.
        do_reset();
        we = '0;
        addr_bus[2*A +: A] = 10'h005;
        addr_bus[1*A +: A] = 10'h005;
        req = 4'b0100;
        step();
        cmp("abort_gnt", 32'(gnt), 32'b0100);
        req = '0;
        step();
        cmp("abort_in_capture", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        cmp("abort_rst_outs", 32'({gnt, ack, busy, ram_ce, ram_we}), 32'd0);
        cmp("abort_rst_addr", 32'(ram_addr), 32'd0);
        cmp("abort_rst_din", 32'(ram_din), 32'd0);
        cmp("abort_rst_rdata", 32'(rdata), 32'd0);
        step();
        cmp("abort_no_ack_rst", 32'(ack), 32'd0);
        reset = 1'b0;
        step();
        cmp("abort_no_ack", 32'(ack), 32'd0);
        req = 4'b1010;
        step();
        cmp("abort_ptr0", 32'(gnt), 32'b0010);
        req = '0;
        step(); step();
        cmp("abort_next_ack", 32'(ack), 32'b0010);
        cmp("abort_next_rdata", 32'(rdata), 32'h1234);

        // Randomized traffic checked purely by the reference model.
        for (int c = 0; c < 1500; c++) begin
            req = N'($urandom);
            we  = N'($urandom);
            for (int i = 0; i < N; i++) begin
                addr_bus[i*A +: A]  = A'($urandom_range(0, 7));
                wdata_bus[i*W +: W] = W'($urandom);
            end
            if (c == 700) reset = 1'b1;
            if (c == 702) reset = 1'b0;
            step();
        end
        req = '0;
        step(); step(); step();
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
